call_request_queue: RTL and testbench
=====================================

CALL_REQUEST_QUEUE -- requirements
Module: call_request_queue

Interface
REQ-001 SHALL have parameters: NFLOORS, 16, number of call buttons and floors; DEPTH, 8, queue entries (power of two, 2..16).
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 btn  input  NFLOORS  call buttons, bit i = floor i, level held while pressed.
REQ-005 fifo_rd  input  1  pop request from the elevator controller.
REQ-006 fifo_empty  output  1  high when the queue holds no entry.
REQ-007 fifo_dout  output  4  floor number at the queue head, first-word-fall-through.
REQ-008 fifo_full  output  1  high when the queue holds DEPTH entries.
REQ-009 fifo_count  output  5  number of queued entries, 0..DEPTH.
REQ-010 pending  output  NFLOORS  call-lamp vector; bit i high while floor i is latched or queued.

Function
REQ-011 Press detect SHALL be a rising edge of a btn bit, with btn_q the btn value registered on the previous clk.
REQ-012 A detected edge for floor i SHALL set latch bit i at that clk edge only if pending[i] was low before that edge; otherwise the press SHALL be dropped.
REQ-013 pending SHALL equal latch OR queued-floor mask; a floor SHALL appear in the queue at most once.
REQ-014 Each cycle with any latch bit set and (count < DEPTH or a valid pop this cycle), the lowest-index set latch bit SHALL be written at the tail and cleared from latch; at most one write per cycle.
REQ-015 If the queue is full and there is no pop, latch bits SHALL hold until space frees; no request SHALL be lost.
REQ-016 fifo_dout SHALL present the head entry combinationally from storage whenever fifo_empty is low; value when empty is don't-care but SHALL be stable (last head).
REQ-017 fifo_rd with fifo_empty high SHALL be ignored with no state change.
REQ-018 fifo_rd with fifo_empty low SHALL advance the head and clear the popped floor's queued-mask bit at that clk edge.
REQ-019 Simultaneous write and pop SHALL both occur; count unchanged; permitted when full.
REQ-020 An edge for floor i in the same cycle floor i is popped SHALL be dropped, because pending[i] was high before the edge.
REQ-021 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be held separately.
REQ-022 fifo_empty = (count == 0); fifo_full = (count == DEPTH); both registered-state derived, no glitch paths from btn.
REQ-023 Latency: btn bit sampled high at edge k (low at k-1) -> latch set at edge k -> entry written at edge k+1 -> fifo_empty low after edge k+1.

Reset
REQ-024 rst high SHALL asynchronously force count=0, pointers=0, latch=0, queued mask=0, btn_q=0, and synchronizer flops to 0.
REQ-025 Reset outputs: fifo_empty=1, fifo_full=0, fifo_count=0, pending=0, fifo_dout=0.
REQ-026 Reset mid-operation SHALL discard all queued and latched requests; buttons held through reset deassertion SHALL register as one new press on the first clk after release.

Configuration
REQ-027 Macro CALL_BTN_SYNC_EN defined: btn SHALL pass through a two-flop synchronizer before edge detect, adding 2 cycles to REQ-023 latency (empty low after edge k+3).
REQ-028 Macro CALL_BTN_SYNC_EN undefined: btn SHALL feed edge detect directly, latency per REQ-023.

Verification
REQ-029 Press btn[5] one cycle, no fifo_rd -> fifo_dout=5, fifo_count=1, pending=0x0020 two edges after press.
REQ-030 Press btn[3], btn[9], btn[1] same cycle -> queue order 1, 3, 9 on consecutive cycles; pending=0x020A throughout.
REQ-031 Press btn[4] twice while queued -> count stays 1; pop -> empty=1, pending=0; press again -> re-queued.
REQ-032 Fill 8 floors 0..7, then press 8 -> full=1, pending[8]=1, count=8; one pop -> floor 8 written same cycle, count stays 8.
REQ-033 fifo_rd while empty -> count 0, no pointer movement; pop floor 2 while btn[2] rises same cycle -> press dropped, empty=1.
REQ-034 Assert rst asynchronously with 5 entries queued -> all outputs at reset values before next clk edge.

Source files
------------

// File: rtl/call_request_queue.sv
// Elevator call-request queue: button press detect, per-floor latch, dedup FIFO of floor numbers.
// Optional CALL_BTN_SYNC_EN inserts a two-flop synchronizer on btn ahead of edge detect.
module call_request_queue #(
  parameter int unsigned NFLOORS = 16,
  parameter int unsigned DEPTH   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NFLOORS-1:0] btn,
  input  logic               fifo_rd,
  output logic               fifo_empty,
  output logic [3:0]         fifo_dout,
  output logic               fifo_full,
  output logic [4:0]         fifo_count,
  output logic [NFLOORS-1:0] pending
);

  localparam int unsigned FW = 4;
  localparam int unsigned CW = 5;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NFLOORS-1:0] w_btn;
  logic [NFLOORS-1:0] r_btn_q;
  logic [NFLOORS-1:0] w_edge;
  logic [NFLOORS-1:0] r_latch;
  logic [NFLOORS-1:0] r_qmask;
  logic [NFLOORS-1:0] w_wr_onehot;
  logic [NFLOORS-1:0] w_pop_onehot;
  logic [NFLOORS-1:0] w_latch_nxt;
  logic [NFLOORS-1:0] w_qmask_nxt;
  logic [FW-1:0]      r_mem [DEPTH];
  logic [AW-1:0]      r_rd_ptr;
  logic [AW-1:0]      r_wr_ptr;
  logic [CW-1:0]      r_count;
  logic [FW-1:0]      w_wr_floor;
  logic               w_pop;
  logic               w_wr;

`ifdef CALL_BTN_SYNC_EN
  logic [NFLOORS-1:0] r_sync1;
  logic [NFLOORS-1:0] r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn = r_sync2;
`else
  assign w_btn = btn;
`endif

  assign w_edge       = w_btn & ~r_btn_q;
  assign pending      = r_latch | r_qmask;
  assign fifo_dout    = r_mem[r_rd_ptr];
  assign fifo_count   = r_count;
  assign fifo_empty   = (r_count == '0);
  assign fifo_full    = (r_count == CW'(DEPTH));
  assign w_pop        = fifo_rd && (r_count != '0);
  assign w_wr         = (r_latch != '0) && ((r_count < CW'(DEPTH)) || w_pop);
  assign w_pop_onehot = NFLOORS'(1) << r_mem[r_rd_ptr];
  // Isolate the lowest set latch bit: that floor is the next one enqueued.
  assign w_wr_onehot  = r_latch & (~r_latch + NFLOORS'(1));

  always_comb begin
    w_wr_floor = '0;
    for (int i = NFLOORS - 1; i >= 0; i--) begin
      if (r_latch[i]) w_wr_floor = FW'(i);
    end
  end

  // A press only latches for a floor with no outstanding request before this edge.
  always_comb begin
    w_latch_nxt = r_latch;
    w_qmask_nxt = r_qmask;
    if (w_wr) begin
      w_latch_nxt = w_latch_nxt & ~w_wr_onehot;
      w_qmask_nxt = w_qmask_nxt | w_wr_onehot;
    end
    if (w_pop) w_qmask_nxt = w_qmask_nxt & ~w_pop_onehot;
    w_latch_nxt = w_latch_nxt | (w_edge & ~pending);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_q  <= '0;
      r_latch  <= '0;
      r_qmask  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_btn_q <= w_btn;
      r_latch <= w_latch_nxt;
      r_qmask <= w_qmask_nxt;
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads as floor 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[r_wr_ptr] <= w_wr_floor;
    end
  end

endmodule

// File: tb/tb_call_request_queue.sv
// Bench for call_request_queue: directed literal checks plus randomized traffic against a queue model.
module tb_call_request_queue;

  localparam int unsigned NF    = 16;
  localparam int unsigned DEPTH = 8;
`ifdef CALL_BTN_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] btn;
  logic          fifo_rd;
  logic          fifo_empty;
  logic [3:0]    fifo_dout;
  logic          fifo_full;
  logic [4:0]    fifo_count;
  logic [NF-1:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  call_request_queue #(.NFLOORS(NF), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .fifo_rd    (fifo_rd),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of floor numbers plus a set of latched floors.
  int            q[$];
  logic [NF-1:0] m_latch;
  logic [NF-1:0] m_prev;
  logic [NF-1:0] m_s1;
  logic [NF-1:0] m_s2;
  logic [NF-1:0] m_b;
  logic [NF-1:0] m_pend;
  logic [NF-1:0] m_new;
  bit            m_pop;
  bit            m_wr;

  function automatic logic [NF-1:0] qmask();
    logic [NF-1:0] m = '0;
    foreach (q[k]) m[q[k]] = 1'b1;
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_latch = '0;
      m_prev  = '0;
      m_s1    = '0;
      m_s2    = '0;
    end else begin
      if (EXTRA != 0) begin
        m_b  = m_s2;
        m_s2 = m_s1;
        m_s1 = btn;
      end else begin
        m_b = btn;
      end
      m_pend = m_latch | qmask();
      m_new  = m_b & ~m_prev & ~m_pend;
      m_pop  = fifo_rd && (q.size() > 0);
      m_wr   = (m_latch != '0) && ((q.size() < int'(DEPTH)) || m_pop);
      if (m_pop) void'(q.pop_front());
      if (m_wr) begin
        for (int i = 0; i < int'(NF); i++) begin
          if (m_latch[i]) begin
            q.push_back(i);
            m_latch[i] = 1'b0;
            break;
          end
        end
      end
      m_latch = m_latch | m_new;
      m_prev  = m_b;
    end
  end

  always @(negedge clk) begin
    check("model_empty", 32'(fifo_empty), 32'(q.size() == 0));
    check("model_full",  32'(fifo_full),  32'(q.size() == int'(DEPTH)));
    check("model_count", 32'(fifo_count), 32'(q.size()));
    check("model_pending", 32'(pending),  32'(m_latch | qmask()));
    if (q.size() > 0) check("model_dout", 32'(fifo_dout), 32'(q[0]));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [NF-1:0] mask);
    btn = mask;
    tick();
    btn = '0;
    repeat (1 + EXTRA) tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_empty"},   32'(fifo_empty), 32'd1);
    check({tag, "_full"},    32'(fifo_full),  32'd0);
    check({tag, "_count"},   32'(fifo_count), 32'd0);
    check({tag, "_pending"}, 32'(pending),    32'd0);
    check({tag, "_dout"},    32'(fifo_dout),  32'd0);
  endtask

  initial begin
    rst = 1'b1;
    btn = '0;
    fifo_rd = 1'b0;
    #12;
    check_reset_vals("reset");
    @(posedge clk);
    #2 rst = 1'b0;
    tick();

    // Single press reaches the head two edges later.
    press(NF'(1) << 5);
    check("p5_dout",    32'(fifo_dout),  32'd5);
    check("p5_count",   32'(fifo_count), 32'd1);
    check("p5_pending", 32'(pending),    32'h0020);
    fifo_rd = 1'b1; tick(); fifo_rd = 1'b0;
    check("p5_pop_empty", 32'(fifo_empty), 32'd1);

    // Simultaneous presses queue lowest floor first.
    btn = 16'h020A;
    tick();
    btn = '0;
    repeat (EXTRA) tick();
    check("multi_latch_pending", 32'(pending), 32'h020A);
    tick();
    check("multi_first_dout", 32'(fifo_dout), 32'd1);
    check("multi_first_pend", 32'(pending),   32'h020A);
    tick(); tick();
    check("multi_count", 32'(fifo_count), 32'd3);
    fifo_rd = 1'b1;
    check("multi_head0", 32'(fifo_dout), 32'd1);
    tick();
    check("multi_head1", 32'(fifo_dout), 32'd3);
    tick();
    check("multi_head2", 32'(fifo_dout), 32'd9);
    tick();
    fifo_rd = 1'b0;
    check("multi_drained", 32'(pending), 32'd0);

    // Duplicate presses while queued are dropped; re-press after pop requeues.
    press(NF'(1) << 4);
    press(NF'(1) << 4);
    check("dup_count", 32'(fifo_count), 32'd1);
    fifo_rd = 1'b1; tick(); fifo_rd = 1'b0;
    check("dup_pop_empty", 32'(fifo_empty), 32'd1);
    check("dup_pop_pend",  32'(pending),    32'd0);
    press(NF'(1) << 4);
    check("dup_requeue_cnt",  32'(fifo_count), 32'd1);
    check("dup_requeue_dout", 32'(fifo_dout),  32'd4);
    fifo_rd = 1'b1; tick(); fifo_rd = 1'b0;

    // Full queue holds the extra request in the latch until a pop frees space.
    btn = 16'h00FF;
    tick();
    btn = '0;
    repeat (8 + EXTRA) tick();
    check("fill_count", 32'(fifo_count), 32'd8);
    press(NF'(1) << 8);
    check("full_flag",    32'(fifo_full),  32'd1);
    check("full_count",   32'(fifo_count), 32'd8);
    check("full_pend8",   32'(pending[8]), 32'd1);
    fifo_rd = 1'b1; tick(); fifo_rd = 1'b0;
    check("full_swap_count", 32'(fifo_count), 32'd8);
    check("full_swap_dout",  32'(fifo_dout),  32'd1);
    check("full_swap_pend",  32'(pending),    32'h01FE);
    fifo_rd = 1'b1; repeat (8) tick(); fifo_rd = 1'b0;
    check("full_drain_empty", 32'(fifo_empty), 32'd1);

    // Pop on empty is ignored; press coinciding with its own pop is dropped.
    fifo_rd = 1'b1; tick(); fifo_rd = 1'b0;
    check("rd_empty_count", 32'(fifo_count), 32'd0);
    press(NF'(1) << 2);
    check("pop_race_pre", 32'(fifo_count), 32'd1);
    fifo_rd = 1'b1;
    btn = NF'(1) << 2;
    tick();
    fifo_rd = 1'b0;
    btn = '0;
    repeat (1 + EXTRA) tick();
    check("pop_race_empty", 32'(fifo_empty), 32'd1);
    check("pop_race_pend",  32'(pending),    32'd0);

    // Asynchronous reset with five entries queued, button held across release.
    btn = 16'h7C00;
    tick();
    btn = '0;
    repeat (5 + EXTRA) tick();
    check("pre_rst_count", 32'(fifo_count), 32'd5);
    #1 rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    btn = NF'(1) << 6;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (2 + EXTRA) tick();
    check("held_count", 32'(fifo_count), 32'd1);
    check("held_dout",  32'(fifo_dout),  32'd6);
    tick(); tick();
    check("held_once", 32'(fifo_count), 32'd1);
    btn = '0;
    fifo_rd = 1'b1; tick(); fifo_rd = 1'b0;

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      btn = NF'($urandom & $urandom & $urandom);
      if ((c / 300) % 2 == 0) fifo_rd = ($urandom_range(0, 3) == 0);
      else                    fifo_rd = ($urandom_range(0, 3) != 0);
      if (c % 1000 == 999) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      tick();
    end
    btn = '0;
    fifo_rd = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
